// File: rtl/load_store_response_tracker.sv
// rtl/load_store_response_tracker.sv - issues LSQ transactions to data memory, tracks and aligns load responses for writeback
module load_store_response_tracker #(
    parameter int ID_W            = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            gc_issue_flush,
    input  logic            txn_valid,
    input  logic [31:0]     txn_addr,
    input  logic            txn_load,
    input  logic            txn_store,
    input  logic [3:0]      txn_be,
    input  logic [2:0]      txn_fn3,
    input  logic [31:0]     txn_data,
    input  logic [ID_W-1:0] txn_id,
    output logic            txn_accepted,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [31:0]     mem_addr,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [31:0]     mem_wdata,
    input  logic            mem_rsp_valid,
    input  logic [31:0]     mem_rsp_data,
    output logic            wb_valid,
    output logic [ID_W-1:0] wb_id,
    output logic [31:0]     wb_data,
    input  logic            wb_ack,
    output logic            unit_idle
);
    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    // Credit: loads issued and not yet written back or discarded
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_next;

    // Per-load attributes, in request order
    logic [ID_W-1:0]            attr_id  [MAX_OUTSTANDING];
    logic [2:0]                 attr_fn3 [MAX_OUTSTANDING];
    logic [1:0]                 attr_off [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] attr_keep;
    logic [AW-1:0]              attr_wr;
    logic [AW-1:0]              attr_rd;
    logic [CW-1:0]              attr_count;
    logic [CW-1:0]              attr_count_next;

    // Completed loads waiting for writeback
    logic [ID_W-1:0]            res_id   [MAX_OUTSTANDING];
    logic [31:0]                res_data [MAX_OUTSTANDING];
    logic [AW-1:0]              res_wr;
    logic [AW-1:0]              res_rd;
    logic [CW-1:0]              res_count;

    logic        load_accept;
    logic        rsp_pop;
    logic        rsp_keep;
    logic        rsp_drop;
    logic        wb_pop;
    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;
    logic [31:0] aligned;

    // Stores bypass the credit check; loads need a free slot
    assign mem_req_valid = rst_n & txn_valid & ~gc_issue_flush & (txn_store | (inflight < MAX_CNT));
    assign txn_accepted  = mem_req_valid & mem_req_ready;
    assign mem_addr      = txn_addr;
    assign mem_we        = txn_store;
    assign mem_be        = txn_be;
    assign mem_wdata     = txn_data;

    assign load_accept = txn_accepted & txn_load;
    // A response with nothing outstanding is ignored entirely
    assign rsp_pop     = mem_rsp_valid & (attr_count != '0);
    assign rsp_keep    = rsp_pop & attr_keep[attr_rd] & ~gc_issue_flush;
    assign rsp_drop    = rsp_pop & ~rsp_keep;

    assign wb_valid  = (res_count != '0);
    assign wb_pop    = wb_valid & wb_ack & ~gc_issue_flush;
    assign wb_id     = wb_valid ? res_id[res_rd] : '0;
    assign wb_data   = wb_valid ? res_data[res_rd] : '0;
    assign unit_idle = (attr_count == '0) & (res_count == '0);

    // Select and extend the loaded byte/halfword from the raw word
    always_comb begin
        rsp_byte = mem_rsp_data[{attr_off[attr_rd], 3'b000} +: 8];
        rsp_half = attr_off[attr_rd][1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
        case (attr_fn3[attr_rd])
            3'b000:  aligned = {{24{rsp_byte[7]}}, rsp_byte};
            3'b100:  aligned = {24'd0, rsp_byte};
            3'b001:  aligned = {{16{rsp_half[15]}}, rsp_half};
            3'b101:  aligned = {16'd0, rsp_half};
            default: aligned = mem_rsp_data;
        endcase
    end

    // Next occupancy and credit; a flush leaves credit only for entries still awaiting data
    always_comb begin
        attr_count_next = attr_count + CW'(load_accept) - CW'(rsp_pop);
        if (gc_issue_flush) begin
            inflight_next = attr_count_next;
        end else begin
            inflight_next = inflight + CW'(load_accept) - CW'(wb_pop) - CW'(rsp_drop);
        end
    end

    // Pointers, counters and keep bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight   <= '0;
            attr_wr    <= '0;
            attr_rd    <= '0;
            attr_count <= '0;
            attr_keep  <= '0;
            res_wr     <= '0;
            res_rd     <= '0;
            res_count  <= '0;
        end else begin
            inflight   <= inflight_next;
            attr_count <= attr_count_next;
            if (load_accept) attr_wr <= attr_wr + AW'(1);
            if (rsp_pop)     attr_rd <= attr_rd + AW'(1);
            if (gc_issue_flush) begin
                attr_keep <= '0;
                res_wr    <= '0;
                res_rd    <= '0;
                res_count <= '0;
            end else begin
                if (load_accept) attr_keep[attr_wr] <= 1'b1;
                if (rsp_keep)    res_wr <= res_wr + AW'(1);
                if (wb_pop)      res_rd <= res_rd + AW'(1);
                res_count <= res_count + CW'(rsp_keep) - CW'(wb_pop);
            end
        end
    end

    // FIFO payload storage
    always_ff @(posedge clk) begin
        if (load_accept) begin
            attr_id[attr_wr]  <= txn_id;
            attr_fn3[attr_wr] <= txn_fn3;
            attr_off[attr_wr] <= txn_addr[1:0];
        end
        if (rsp_keep) begin
            res_id[res_wr]   <= attr_id[attr_rd];
            res_data[res_wr] <= aligned;
        end
    end

    // Memory must never return data that was not requested
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(mem_rsp_valid && (attr_count == '0)));
        end
    end

endmodule

// File: doc/load_store_response_tracker.md
# load_store_response_tracker

Downstream stage of the load/store queue in the load/store unit. It takes the oldest queued transaction and issues it to the data-memory sub-unit. For every issued load it tracks attributes in order and aligns and sign-extends the returned data. It then presents completed loads to writeback by ID, and it handles issue flushes that land while loads are outstanding.

## Interface
Parameters:
- ID_W, 3: width of an instruction ID (MAX_IDS = 8)
- MAX_OUTSTANDING, 4: loads issued but not yet acknowledged by writeback (power of 2, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- gc_issue_flush  in  1  squash all un-written-back loads
- txn_valid  in  1  queue has an oldest transaction (queue's transaction_ready)
- txn_addr  in  32  byte address
- txn_load / txn_store  in  1 / 1  transaction type (exactly one set)
- txn_be  in  4  store byte enables
- txn_fn3  in  3  RISC-V funct3
- txn_data  in  32  pre-aligned store data
- txn_id  in  ID_W  transaction ID
- txn_accepted  out  1  transaction consumed this cycle (queue's accepted/pop)
- mem_req_valid  out  1  request to memory sub-unit
- mem_req_ready  in  1  sub-unit takes request this cycle
- mem_addr  out  32; mem_we  out  1; mem_be  out  4; mem_wdata  out  32
- mem_rsp_valid  in  1  load data returned, strictly in request order, cannot be stalled
- mem_rsp_data  in  32  raw word
- wb_valid  out  1  completed load available
- wb_id  out  ID_W; wb_data  out  32
- wb_ack  in  1  writeback consumes the head result
- unit_idle  out  1  no load outstanding or pending writeback

## Operation
- Credit counter `inflight` (0..MAX_OUTSTANDING): +1 on each accepted load, −1 on each wb_ack, −1 on each discarded response.
- Request path (combinational): mem_req_valid = txn_valid & ~gc_issue_flush & (txn_store | inflight < MAX_OUTSTANDING).
  - mem_addr = txn_addr; mem_we = txn_store; mem_be = txn_be; mem_wdata = txn_data.
  - txn_accepted = mem_req_valid & mem_req_ready.
  - Stores never consume credit.
- Attribute FIFO, depth MAX_OUTSTANDING: each accepted load pushes {id, fn3, addr[1:0], keep=1}; each mem_rsp_valid pops the head.
- Alignment by the popped entry:
  - fn3 000 LB: byte at addr[1:0], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword at addr[1], sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 and all other codes: full word.
- Result FIFO, depth MAX_OUTSTANDING, holds {id, aligned data}.
  - A response whose entry has keep=1 is pushed, registered.
  - wb_valid = result FIFO non-empty; wb_id/wb_data = head; head pops on wb_valid & wb_ack.
  - Credit guarantees the result FIFO never overflows.
- Flush (gc_issue_flush=1):
  - No request accepted in that cycle.
  - Result FIFO emptied.
  - keep cleared on all attribute entries, including any pushed that cycle (none are).
  - inflight set to the attribute-FIFO occupancy after that cycle's pop.
  - Responses arriving in the flush cycle or later for cleared entries pop the attribute FIFO, are dropped, and return credit.
  - wb_ack in a flush cycle is ignored.
- Simultaneous events:
  - Accept plus ack or discard in one cycle: counter nets to zero change.
  - Push plus pop on a full attribute FIFO is legal only when popping (credit prevents a push to a full FIFO otherwise).
- mem_rsp_valid with an empty attribute FIFO is a protocol error: ignored, and an assertion fires.
- unit_idle = attribute FIFO empty & result FIFO empty.

## Timing
- Reset (rst_n low, any time, including mid-transfer): FIFOs empty, inflight=0, all keep bits cleared.
  - wb_valid=0, wb_id=0, wb_data=0, unit_idle=1.
  - mem_req_valid=0 and txn_accepted=0 while in reset.
  - Outstanding responses after release are treated as protocol errors.
- Request issue: 0-cycle combinational pass-through, one transaction per cycle.
- Load latency: mem_rsp_valid in cycle N → wb_valid=1 in cycle N+1.
- Throughput: one response per cycle; one writeback per cycle with wb_ack held high.
- Credit returns in the cycle after wb_ack, so a full unit can accept a new load in the cycle after the ack.
- Flush takes effect in its own cycle: wb_valid=0 in cycle flush+1 unless a non-flushed response arrives in that cycle.

## Test plan
- LB/LBU: txn_addr=0x103, mem_rsp_data=0x80123456 → wb_data 0xFFFFFF80 (LB), 0x00000080 (LBU), with the matching ID, one cycle after the response.
- LH/LHU: txn_addr=0x102, mem_rsp_data=0xBEEF1234 → 0xFFFFBEEF (LH), 0x0000BEEF (LHU); LW at 0x100 → 0xBEEF1234.
- Credit full: issue 4 loads with responses withheld and wb_ack=0.
  - 5th load: txn_accepted=0.
  - Store presented next: accepted.
  - Return 4 responses, then ack one: the 5th load is accepted in the cycle after the ack.
- Backpressure ordering: 3 loads with IDs 5, 2, 7, responses back-to-back, wb_ack low for 5 cycles then high → writebacks appear in order 5, 2, 7 with correct data.
- Flush: 2 loads outstanding plus 1 completed result pending; assert gc_issue_flush.
  - wb_valid drops the next cycle.
  - Both later responses are dropped.
  - inflight returns to 0 and unit_idle=1.
  - A following load completes normally.
- Reset mid-operation: deassert rst_n with 3 loads outstanding → all outputs at reset values immediately (asynchronous), unit_idle=1, a fresh load after release completes correctly.
